// File: rtl/dmem_arbiter_pkg.sv
// Shared state encoding and grant identifiers for the data SRAM sequencer.
// Used by the arbiter FSM and by its round-robin helper.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam logic       GNT_CORE = 1'b0;
    localparam logic       GNT_DBG  = 1'b1;
    localparam logic [3:0] BE_ALL   = 4'hF;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin: single requester wins; on a tie the port not granted last wins.
// Zero latency; no backpressure of its own, the caller samples gnt only when it can start an access.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       any
);

    assign any = |req;

    always_comb begin
        gnt = GNT_CORE;
        if (req == 2'b11) begin
            gnt = ~last;
        end else if (req[1]) begin
            gnt = GNT_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/debug arbiter and strobe sequencer for the 32-bit async SRAM pair; 4 cycles per access, ready in cycle N+3.
// Backpressure: a requester holds req until its one-cycle ready pulse; the loser waits for the next IDLE.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [3:0]        core_be,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_ready,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ready,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i
);

    state_t              r_state;
    state_t              w_next;
    logic                r_last_grant;
    logic                r_gnt;
    logic                r_we;
    logic [3:0]          r_be;
    logic                r_ce_n;
    logic                r_oe_n;
    logic                r_we_n;
    logic [3:0]          r_be_n;
    logic                r_dq_oe;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_dq_o;
    logic                r_core_ready;
    logic                r_dbg_ready;
    logic [DATA_W-1:0]   r_core_rdata;
    logic [DATA_W-1:0]   r_dbg_rdata;

    logic                w_gnt;
    logic                w_any;
    logic                w_sel_we;
    logic [3:0]          w_sel_be;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req  ({dbg_req, core_req}),
        .last (r_last_grant),
        .gnt  (w_gnt),
        .any  (w_any)
    );

    // Loads always enable every lane; the backend extracts bytes/halfwords.
    assign w_sel_we    = (w_gnt == GNT_DBG) ? dbg_we    : core_we;
    assign w_sel_be    = !w_sel_we ? BE_ALL : ((w_gnt == GNT_DBG) ? BE_ALL : core_be);
    assign w_sel_addr  = (w_gnt == GNT_DBG) ? dbg_addr  : core_addr;
    assign w_sel_wdata = (w_gnt == GNT_DBG) ? dbg_wdata : core_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_any) w_next = ST_SETUP;
            ST_SETUP:   w_next = ST_STROBE;
            ST_STROBE:  w_next = ST_RECOVER;
            ST_RECOVER: w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= GNT_DBG;
            r_gnt        <= GNT_CORE;
            r_we         <= 1'b0;
            r_be         <= 4'h0;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_be_n       <= 4'hF;
            r_dq_oe      <= 1'b0;
            r_addr       <= '0;
            r_dq_o       <= '0;
            r_core_ready <= 1'b0;
            r_dbg_ready  <= 1'b0;
            r_core_rdata <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt        <= w_gnt;
                        r_last_grant <= w_gnt;
                        r_we         <= w_sel_we;
                        r_be         <= w_sel_be;
                        r_addr       <= w_sel_addr;
                        r_dq_o       <= w_sel_wdata;
                        r_ce_n       <= 1'b0;
                        r_oe_n       <= w_sel_we;
                        r_be_n       <= ~w_sel_be;
                        r_dq_oe      <= w_sel_we;
                    end
                end
                ST_SETUP: begin
                    // A store with no lanes enabled runs the full sequence without a write pulse.
                    if (r_we && (r_be != 4'h0)) begin
                        r_we_n <= 1'b0;
                    end
                end
                ST_STROBE: begin
                    if (!r_we) begin
                        if (r_gnt == GNT_DBG) r_dbg_rdata  <= sram_dq_i;
                        else                  r_core_rdata <= sram_dq_i;
                    end
                    r_ce_n       <= 1'b1;
                    r_oe_n       <= 1'b1;
                    r_we_n       <= 1'b1;
                    r_be_n       <= 4'hF;
                    r_dq_oe      <= 1'b0;
                    r_core_ready <= (r_gnt == GNT_CORE);
                    r_dbg_ready  <= (r_gnt == GNT_DBG);
                end
                ST_RECOVER: begin
                    r_core_ready <= 1'b0;
                    r_dbg_ready  <= 1'b0;
                end
                default: begin
                    r_core_ready <= 1'b0;
                    r_dbg_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign sram_ce_n  = r_ce_n;
    assign sram_oe_n  = r_oe_n;
    assign sram_we_n  = r_we_n;
    assign sram_be_n  = r_be_n;
    assign sram_addr  = r_addr;
    assign sram_dq_o  = r_dq_o;
    assign sram_dq_oe = r_dq_oe;
    assign core_ready = r_core_ready;
    assign core_rdata = r_core_rdata;
    assign dbg_ready  = r_dbg_ready;
    assign dbg_rdata  = r_dbg_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: SRAM pair model, transaction-level reference model and per-cycle strobe/data compare.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [3:0]  core_be = 4'h0;
    logic [15:0] core_addr = 16'h0;
    logic [31:0] core_wdata = 32'h0;
    logic        core_ready;
    logic [31:0] core_rdata;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [15:0] dbg_addr = 16'h0;
    logic [31:0] dbg_wdata = 32'h0;
    logic        dbg_ready;
    logic [31:0] dbg_rdata;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe;
    logic [3:0]  sram_be_n;
    logic [15:0] sram_addr;
    logic [31:0] sram_dq_o, sram_dq_i;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_be(core_be), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_ready(core_ready), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready), .dbg_rdata(dbg_rdata),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_be_n(sram_be_n), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i)
    );

    int n_chk = 0;
    int n_pass = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    endfunction

    // SRAM pair: asynchronous read, lane writes while CE and WE are both low.
    logic [31:0] sram_mem [0:65535];
    logic [31:0] ref_mem  [0:65535];
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 32'h0BADF00D;

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            for (int i = 0; i < 4; i++)
                if (!sram_be_n[i]) sram_mem[sram_addr][8*i +: 8] <= sram_dq_o[8*i +: 8];
        end
    end

    // Reference model: one access starts on a sampling edge, the next sampling edge is 4 later.
    int          cyc = 0;
    int          next_edge = 1;
    int          s = -100;
    bit          t_we = 1'b0, t_g = 1'b0, last_g = 1'b1;
    logic [3:0]  t_be = 4'hF;
    logic [15:0] t_addr = 16'h0;
    logic [31:0] t_wd = 32'h0, t_rd = 32'h0;
    logic [31:0] exp_core_rd = 32'h0, exp_dbg_rd = 32'h0;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            next_edge = cyc + 1;
        end else begin
            if (cyc == s + 2 && !t_we) begin
                if (t_g) exp_dbg_rd = t_rd;
                else     exp_core_rd = t_rd;
            end
            if (cyc == next_edge) begin
                if (core_req || dbg_req) begin
                    t_g    = (core_req && dbg_req) ? !last_g : dbg_req;
                    last_g = t_g;
                    s      = cyc;
                    next_edge = cyc + 4;
                    t_we   = t_g ? dbg_we : core_we;
                    t_be   = (t_we && !t_g) ? core_be : 4'hF;
                    t_addr = t_g ? dbg_addr : core_addr;
                    t_wd   = t_g ? dbg_wdata : core_wdata;
                    if (t_we) begin
                        for (int i = 0; i < 4; i++)
                            if (t_be[i]) ref_mem[t_addr][8*i +: 8] = t_wd[8*i +: 8];
                    end else begin
                        t_rd = ref_mem[t_addr];
                    end
                end else begin
                    next_edge = cyc + 1;
                end
            end
        end
    end

    always @(negedge rst) begin
        s = -100;
        last_g = 1'b1;
        exp_core_rd = 32'h0;
        exp_dbg_rd = 32'h0;
    end

    // Per-cycle compare against the model, plus a log of observed ready pulses.
    int         ph;
    logic [9:0] a_vec, e_vec;
    int         r_cyc[$];
    bit         r_port[$];

    always @(negedge clk) begin
        ph = cyc - s;
        a_vec = {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe, core_ready, dbg_ready};
        if (ph == 0)      e_vec = {1'b0, t_we, 1'b1, ~t_be, t_we, 2'b00};
        else if (ph == 1) e_vec = {1'b0, t_we, !(t_we && (t_be != 4'h0)), ~t_be, t_we, 2'b00};
        else if (ph == 2) e_vec = {3'b111, 4'hF, 1'b0, !t_g, t_g};
        else              e_vec = {3'b111, 4'hF, 1'b0, 2'b00};
        chk("strobes_ready", a_vec, e_vec);
        if (ph >= 0 && ph <= 2) chk("sram_addr", sram_addr, t_addr);
        if (t_we && ph >= 0 && ph <= 1) chk("sram_dq_o", sram_dq_o, t_wd);
        chk("core_rdata", core_rdata, exp_core_rd);
        chk("dbg_rdata", dbg_rdata, exp_dbg_rd);
        chk("bus_contention", sram_dq_oe & ~sram_oe_n, 1'b0);
        if (core_ready) begin r_cyc.push_back(cyc); r_port.push_back(1'b0); end
        if (dbg_ready)  begin r_cyc.push_back(cyc); r_port.push_back(1'b1); end
    end

    task automatic access(input bit p, input bit we, input logic [3:0] be, input logic [15:0] a,
                          input logic [31:0] d, input bit settle, output int lat);
        int n = 0;
        bit got = 1'b0;
        if (p) begin dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_req = 1'b1; end
        else   begin core_we = we; core_be = be; core_addr = a; core_wdata = d; core_req = 1'b1; end
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = p ? dbg_ready : core_ready;
        end
        if (!got) chk("ready_timeout", got, 1'b1);
        if (p) dbg_req = 1'b0; else core_req = 1'b0;
        lat = n;
        if (settle) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    int lat;
    int rel_cyc;

    initial begin
        for (int i = 0; i < 65536; i++) begin sram_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        @(negedge clk);
        chk("reset_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe, core_ready, dbg_ready},
            10'b111_1111_000);
        chk("reset_addr_data", {sram_addr, sram_dq_o}, 48'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Core store then load.
        access(1'b0, 1'b1, 4'hF, 16'h0010, 32'hDEADBEEF, 1'b1, lat);
        chk("store_latency", lat, 3);
        access(1'b0, 1'b0, 4'hF, 16'h0010, 32'h0, 1'b1, lat);
        chk("load_latency", lat, 3);
        chk("load_data_lit", core_rdata, 32'hDEADBEEF);
        access(1'b1, 1'b0, 4'hF, 16'h0010, 32'h0, 1'b1, lat);
        chk("dbg_load_lit", dbg_rdata, 32'hDEADBEEF);

        // Byte store into a preloaded word.
        access(1'b1, 1'b1, 4'hF, 16'h0020, 32'h11223344, 1'b1, lat);
        access(1'b0, 1'b1, 4'b0100, 16'h0020, 32'hAAAAAAAA, 1'b1, lat);
        access(1'b0, 1'b0, 4'hF, 16'h0020, 32'h0, 1'b1, lat);
        chk("byte_store_lit", core_rdata, 32'h11AA3344);

        // Store with no byte enables leaves memory untouched.
        access(1'b1, 1'b1, 4'hF, 16'h0030, 32'h12345678, 1'b1, lat);
        access(1'b0, 1'b1, 4'h0, 16'h0030, 32'hFFFFFFFF, 1'b1, lat);
        chk("zero_be_latency", lat, 3);
        access(1'b0, 1'b0, 4'hF, 16'h0030, 32'h0, 1'b1, lat);
        chk("zero_be_lit", core_rdata, 32'h12345678);

        // Reset during the write strobe.
        core_we = 1'b1; core_be = 4'hF; core_addr = 16'h0100; core_wdata = 32'h55AA55AA; core_req = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (sram_we_n && lat < 10);
        chk("rst_reach_strobe", sram_we_n, 1'b0);
        r_cyc.delete(); r_port.delete();
        #1 rst = 1'b0; core_req = 1'b0;
        #1 chk("rst_async_strobes", {sram_we_n, sram_ce_n, sram_dq_oe, core_ready}, 4'b1100);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_ready", r_cyc.size(), 0);
        access(1'b0, 1'b0, 4'hF, 16'h0010, 32'h0, 1'b1, lat);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_data", core_rdata, 32'hDEADBEEF);

        // Both ports requesting from reset release: strict alternation, core first.
        rst = 1'b0;
        core_we = 1'b0; core_addr = 16'h0010; core_req = 1'b1;
        dbg_we = 1'b0;  dbg_addr = 16'h0020;  dbg_req = 1'b1;
        repeat (2) @(negedge clk);
        r_cyc.delete(); r_port.delete();
        rst = 1'b1;
        rel_cyc = cyc;
        lat = 0;
        while (r_cyc.size() < 4 && lat < 40) begin @(negedge clk); lat++; end
        core_req = 1'b0; dbg_req = 1'b0;
        if (r_cyc.size() >= 4) begin
            chk("tie_first_latency", r_cyc[0] - rel_cyc, 3);
            for (int k = 0; k < 4; k++) chk("tie_order", r_port[k], k % 2);
            for (int k = 1; k < 4; k++) chk("tie_interval", r_cyc[k] - r_cyc[k-1], 4);
        end else begin
            chk("tie_count", r_cyc.size(), 4);
        end
        repeat (6) @(negedge clk);
        chk("tie_core_data", core_rdata, 32'hDEADBEEF);
        chk("tie_dbg_data", dbg_rdata, 32'h11AA3344);

        // Mixed random traffic on both ports.
        fork
            begin
                int lc;
                for (int i = 0; i < 120; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    access(1'b0, 1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom_range(0, 63)),
                           $urandom, 1'b0, lc);
                end
            end
            begin
                int ld;
                for (int i = 0; i < 120; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    access(1'b1, 1'($urandom_range(0, 1)), 4'hF, 16'($urandom_range(0, 63)),
                           $urandom, 1'b0, ld);
                end
            end
        join
        repeat (8) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
